// File: rtl/clb_config_loader.sv
// Configuration sequencer: stages one word per logic pair in shadow registers, then commits all pairs at once.
// Optional feature macro CFG_PARITY_EN: 23-bit words with even parity; a bad word aborts the session.
module clb_config_loader #(
    parameter int NUM_PAIRS = 4,
    parameter int PTR_W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
`ifdef CFG_PARITY_EN
    input  logic [22:0]              cfg_data,
`else
    input  logic [21:0]              cfg_data,
`endif
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    output logic                     prgm_b,
    output logic [NUM_PAIRS-1:0]     CLB_prgm_b,
    output logic [16*NUM_PAIRS-1:0]  look_up_t,
    output logic [NUM_PAIRS-1:0]     switch,
    output logic [NUM_PAIRS-1:0]     carryOut_sel_mux,
    output logic [NUM_PAIRS-1:0]     bypass,
    output logic [3*NUM_PAIRS-1:0]   CYMUX0_select,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PTR_W-1:0] r_ptr;
    logic             r_error;
    logic             w_xfer;
    logic             w_accept;
    logic             w_last;
    logic             w_par_err;
    logic             w_commit;

    assign w_xfer = (r_state == S_LOAD) && cfg_valid;
`ifdef CFG_PARITY_EN
    assign w_par_err = ^cfg_data;
`else
    assign w_par_err = 1'b0;
`endif
    assign w_accept = w_xfer && !w_par_err;
    assign w_last   = (r_ptr == PTR_W'(NUM_PAIRS - 1));
    assign w_commit = (r_state == S_COMMIT);
    assign error    = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        busy         = 1'b0;
        prgm_b       = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                // A corrupted word abandons the session before anything reaches the array
                if (w_xfer) begin
                    if (w_par_err) begin
                        w_state_next = S_IDLE;
                    end else if (w_last) begin
                        w_state_next = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                prgm_b       = 1'b0;
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_error <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_ptr   <= '0;
                r_error <= 1'b0;
            end else if (w_accept) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
            if (w_xfer && w_par_err) begin
                r_error <= 1'b1;
            end
        end
    end

    // Per pair: shadow captures its word during LOAD, committed copy follows only on COMMIT
    generate
        for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
            logic [21:0] r_shadow;
            logic [21:0] r_cfg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shadow <= '0;
                    r_cfg    <= '0;
                end else begin
                    if (w_accept && (r_ptr == PTR_W'(gi))) begin
                        r_shadow <= cfg_data[21:0];
                    end
                    if (w_commit) begin
                        r_cfg <= r_shadow;
                    end
                end
            end

            assign look_up_t[16*gi +: 16]    = r_cfg[21:6];
            assign switch[gi]                = r_cfg[5];
            assign carryOut_sel_mux[gi]      = r_cfg[4];
            assign bypass[gi]                = r_cfg[3];
            assign CYMUX0_select[3*gi +: 3]  = r_cfg[2:0];
            assign CLB_prgm_b[gi]            = prgm_b;
        end
    endgenerate

endmodule

// File: tb/tb_clb_config_loader.sv
// Self-checking bench for clb_config_loader: directed sessions plus randomized words/handshakes vs. a session-level model.
module tb_clb_config_loader;

    localparam int NP = 4;
    localparam int PW = 4;
`ifdef CFG_PARITY_EN
    localparam int CW = 23;
`else
    localparam int CW = 22;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cfg_valid;
    logic [CW-1:0]     cfg_data;
    logic              cfg_ready;
    logic              prgm_b;
    logic [NP-1:0]     CLB_prgm_b;
    logic [16*NP-1:0]  look_up_t;
    logic [NP-1:0]     switch_o;
    logic [NP-1:0]     carry_o;
    logic [NP-1:0]     bypass_o;
    logic [3*NP-1:0]   cymux_o;
    logic              busy;
    logic              done;
    logic              error;

    int vectors     = 0;
    int miscompares = 0;

    logic [21:0] stim    [NP];
    logic [21:0] exp_cfg [NP];
    logic        exp_err;

    always #5 clk = ~clk;

    clb_config_loader #(
        .NUM_PAIRS (NP),
        .PTR_W     (PW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .cfg_data         (cfg_data),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .prgm_b           (prgm_b),
        .CLB_prgm_b       (CLB_prgm_b),
        .look_up_t        (look_up_t),
        .switch           (switch_o),
        .carryOut_sel_mux (carry_o),
        .bypass           (bypass_o),
        .CYMUX0_select    (cymux_o),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic r, input logic b,
                                input logic p, input logic d, input logic e);
        check({tag, "/cfg_ready"},  64'(cfg_ready), 64'(r));
        check({tag, "/busy"},       64'(busy),      64'(b));
        check({tag, "/prgm_b"},     64'(prgm_b),    64'(p));
        check({tag, "/CLB_prgm_b"}, 64'(CLB_prgm_b), p ? 64'({NP{1'b1}}) : 64'(0));
        check({tag, "/done"},       64'(done),      64'(d));
        check({tag, "/error"},      64'(error),     64'(e));
    endtask

    // Expected array-facing fields assembled from the committed words
    task automatic check_cfg(input string tag);
        logic [63:0] l = '0;
        logic [63:0] s = '0;
        logic [63:0] c = '0;
        logic [63:0] b = '0;
        logic [63:0] m = '0;
        for (int i = 0; i < NP; i++) begin
            l[16*i +: 16] = exp_cfg[i][21:6];
            s[i]          = exp_cfg[i][5];
            c[i]          = exp_cfg[i][4];
            b[i]          = exp_cfg[i][3];
            m[3*i +: 3]   = exp_cfg[i][2:0];
        end
        check({tag, "/look_up_t"},        64'(look_up_t), l);
        check({tag, "/switch"},           64'(switch_o),  s);
        check({tag, "/carryOut_sel_mux"}, 64'(carry_o),   c);
        check({tag, "/bypass"},           64'(bypass_o),  b);
        check({tag, "/CYMUX0_select"},    64'(cymux_o),   m);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NP; i++) begin
            stim[i] = 22'($urandom);
        end
    endtask

    // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
    // poke: random start pulses during LOAD plus start/valid held through COMMIT and DONE.
    task automatic run_session(input int id, input int mode, input bit poke,
                               input int abort_at, input int bad_idx);
        int taken;
        int lc;
        bit v;
        taken = 0;
        lc    = 0;
        start = 1'b1;
        cfg_valid = 1'b0;
        tick();
        start   = 1'b0;
        exp_err = 1'b0;
        check_status("load_entry", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        while (taken < NP && lc < 1000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (lc % 2 == 1);
                default: v = ($urandom_range(99) < 60);
            endcase
            cfg_valid = v;
            if (v) begin
`ifdef CFG_PARITY_EN
                cfg_data = {(^stim[taken]) ^ (taken == bad_idx), stim[taken]};
`else
                cfg_data = stim[taken];
`endif
            end else begin
                cfg_data = CW'($urandom);
            end
            start = poke ? 1'($urandom_range(1)) : 1'b0;
            tick();
            lc++;
            if (v) taken++;
            if (v && (taken - 1 == bad_idx)) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
                exp_err   = 1'b1;
                check_status("par_abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
                check_cfg("par_abort");
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check_status("par_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
                    check_cfg("par_idle");
                end
                $display("session %0d: parity abort at word %0d, config retained", id, bad_idx);
                return;
            end
            if (v && (taken == abort_at)) begin
                reset     = 1'b1;
                cfg_valid = 1'b0;
                start     = 1'b0;
                tick();
                reset = 1'b0;
                for (int i = 0; i < NP; i++) exp_cfg[i] = '0;
                check_status("rst_abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                check_cfg("rst_abort");
                tick();
                check_status("rst_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                $display("session %0d: reset after %0d words, outputs cleared", id, taken);
                return;
            end
            if (taken < NP) begin
                check_status("load", 1'b1, 1'b1, 1'b1, 1'b0, exp_err);
                check_cfg("load");
            end
        end
        if (taken < NP) begin
            vectors++;
            miscompares++;
            $display("FAIL load_timeout words=%0d required=%0d", taken, NP);
        end
        // COMMIT cycle: old config still visible, strobe low
        cfg_valid = poke;
        cfg_data  = CW'($urandom);
        start     = poke;
        check_status("commit", 1'b0, 1'b1, 1'b0, 1'b0, exp_err);
        check_cfg("commit");
        tick();
        for (int i = 0; i < NP; i++) exp_cfg[i] = stim[i];
        check_status("done", 1'b0, 1'b0, 1'b1, 1'b1, exp_err);
        check_cfg("done");
        tick();
        check_status("idle", 1'b0, 1'b0, 1'b1, 1'b0, exp_err);
        start     = 1'b0;
        cfg_valid = 1'b0;
        tick();
        check_status("idle2", 1'b0, 1'b0, 1'b1, 1'b0, exp_err);
        check_cfg("idle2");
        $display("session %0d: mode=%0d load_cycles=%0d committed", id, mode, lc);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = '0;
        exp_err   = 1'b0;
        for (int i = 0; i < NP; i++) exp_cfg[i] = '0;
        tick();
        tick();
        start     = 1'b0;
        cfg_valid = 1'b0;
        check_status("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_cfg("reset");
        reset = 1'b0;

        cfg_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cfg_data = CW'($urandom);
            tick();
            check({"idle_valid/cfg_ready"}, 64'(cfg_ready), 64'(0));
            check({"idle_valid/busy"},      64'(busy),      64'(0));
        end
        check_cfg("idle_valid");
        cfg_valid = 1'b0;
        $display("idle: 100 cycles with cfg_valid high, nothing accepted");

        for (int i = 0; i < NP; i++) begin
            stim[i] = {16'hA5A5 + 16'(i), 1'b1, 1'b0, 1'b0, 3'd5};
        end
        run_session(1, 0, 1'b0, -1, -1);
        check("directed/look_up_t", 64'(look_up_t), 64'hA5A8_A5A7_A5A6_A5A5);

        fill_random();
        run_session(2, 1, 1'b0, -1, -1);
        fill_random();
        run_session(3, 0, 1'b0, 2, -1);
        fill_random();
        run_session(4, 0, 1'b0, -1, -1);
        fill_random();
        run_session(5, 2, 1'b1, -1, -1);
`ifdef CFG_PARITY_EN
        fill_random();
        run_session(6, 0, 1'b0, -1, 2);
        fill_random();
        run_session(7, 0, 1'b0, -1, -1);
`endif
        for (int s = 0; s < 6; s++) begin
            fill_random();
            run_session(10 + s, 2, (s % 2 == 1), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clb_config_loader.md
Name: clb_config_loader

Overview:
- Configuration sequencer for an array of NUM_PAIRS logic-pair cells (4-input LUT, fast carry chain, FF/LUT output mux).
- Accepts configuration words over a valid/ready stream and stages them in shadow registers, one per pair.
- Commits all staged words atomically with a one-cycle programming strobe.
- Sits between the bitstream front end and the CLB array; the array sees configuration change only at commit.

Parameters:
NUM_PAIRS, 4, number of logic pairs configured (1..16)
PTR_W, 4, width of the pair index pointer; must satisfy 2**PTR_W >= NUM_PAIRS

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a configuration session
cfg_data  input  22  {lut[15:0], switch, carryOut_sel_mux, bypass, CYMUX0_select[2:0]} (MSB..LSB); 23 bits when CFG_PARITY_EN, bit 22 = even parity
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  loader accepts cfg_data this cycle
prgm_b  output  1  global program strobe, active-low
CLB_prgm_b  output  NUM_PAIRS  per-pair program enable, active-low
look_up_t  output  16*NUM_PAIRS  committed LUT contents; pair i at [16i+15:16i]
switch  output  NUM_PAIRS  committed FF/LUT output select
carryOut_sel_mux  output  NUM_PAIRS  committed carry-out select
bypass  output  NUM_PAIRS  committed carry bypass
CYMUX0_select  output  3*NUM_PAIRS  committed carry mux select; pair i at [3i+2:3i]
busy  output  1  session in progress
done  output  1  one-cycle pulse after commit
error  output  1  sticky error flag, cleared by start or reset

Behaviour:
- Reset (synchronous, active-high, on clk rising edge):
  - State IDLE; pointer 0.
  - cfg_ready, busy, done, error = 0.
  - prgm_b = 1; CLB_prgm_b all 1.
  - All committed and shadow config registers = 0.
- States: IDLE, LOAD, COMMIT, DONE.
- IDLE:
  - cfg_ready = 0; cfg_valid is ignored.
  - start = 1 -> LOAD; pointer := 0; error := 0.
- LOAD:
  - busy = 1; cfg_ready = 1.
  - Handshake: a transfer occurs in a cycle where cfg_valid && cfg_ready.
  - On a transfer, cfg_data is written to shadow[pointer] and pointer increments.
  - The transfer with pointer == NUM_PAIRS-1 -> COMMIT, with cfg_ready deasserting the next cycle. No wrap-around; extra words are not accepted.
  - cfg_valid low holds the state indefinitely with no timeout.
  - start while in LOAD is ignored.
- COMMIT (exactly 1 cycle):
  - prgm_b = 0; CLB_prgm_b = all 0; cfg_ready = 0; busy = 1.
  - Committed outputs load from shadow registers at the end of this cycle, so the new values are visible the cycle after COMMIT.
  - -> DONE.
- DONE (1 cycle): done = 1; busy = 0; -> IDLE.
- Latency: start to done = NUM_PAIRS transfer cycles (minimum) + 2.
- Committed outputs only change on COMMIT exit or reset; partial loads never reach the array.
- Reset mid-LOAD or mid-COMMIT:
  - Returns to the reset state.
  - Committed outputs are zeroed.
  - Shadow contents are discarded.
- start and the final transfer in the same cycle: start is ignored.
- start during DONE: ignored. The pulse must be reissued in IDLE.

Optional Feature:
- Macro: CFG_PARITY_EN.
- Defined:
  - cfg_data is 23 bits.
  - Each accepted word is checked for even parity over all 23 bits.
  - Mismatch: error := 1; the state goes to IDLE without COMMIT; prgm_b stays 1; committed outputs are unchanged; done is not pulsed.
- Undefined:
  - cfg_data is 22 bits; no check is made; error stays 0.

Test Plan:
- NUM_PAIRS=4, reset, start, 4 back-to-back words (lut=16'hA5A5+i, switch=1, CYMUX0_select=3'd5) -> prgm_b low exactly 1 cycle; look_up_t=64'hA5A8_A5A7_A5A6_A5A5 the following cycle; done pulse at start+6.
- Same session with cfg_valid toggled every other cycle -> exactly 4 transfers; outputs unchanged until COMMIT; done at start+10.
- Reset asserted after 2 transfers -> all outputs 0, cfg_ready=0, no prgm_b pulse; a subsequent full session loads correctly.
- Second session with start pulsed during LOAD and cfg_valid held high after the last word -> start ignored; cfg_ready=0 from the cycle after the 4th transfer; 5th word not accepted.
- CFG_PARITY_EN: 3rd word with a flipped parity bit -> error=1, no prgm_b pulse, prior committed config retained; next start clears error.
- Reset then idle 100 cycles with cfg_valid=1 -> cfg_ready stays 0, no state change.
